lc3_memory_responder: RTL
=========================

LC3_MEMORY_RESPONDER -- requirements
Module: lc3_memory_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before ready (0..15).
REQ-002 SHALL have parameter ADDR_BITS, default 12, meaning RAM depth is 2**ADDR_BITS words of 16 bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_en  input  1  CPU access request, held high until ready.
REQ-006 SHALL have port r_w  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr  input  16  word address (MAR).
REQ-008 SHALL have port wdata  input  16  write data (MDR).
REQ-009 SHALL have port rdata  output  16  read data, valid while ready=1.
REQ-010 SHALL have port ready  output  1  access complete (LC-3 R signal).
REQ-011 SHALL have port kb_strobe  input  1  one-cycle pulse: new keyboard character.
REQ-012 SHALL have port kb_char  input  8  keyboard character.
REQ-013 SHALL have port disp_valid  output  1  display character pending.
REQ-014 SHALL have port disp_char  output  8  display character.
REQ-015 SHALL have port disp_ack  input  1  display consumed character.
REQ-016 SHALL have port kbd_int  output  1  keyboard interrupt request = KBSR[15] & KBSR[14].

Function
REQ-017 SHALL implement FSM MEM_IDLE, MEM_WAIT, MEM_RESP.
REQ-018 In MEM_IDLE with mem_en=1, SHALL capture addr, r_w, wdata, load wait counter with WAIT_CYCLES, go to MEM_WAIT (directly to MEM_RESP if WAIT_CYCLES=0).
REQ-019 In MEM_WAIT, SHALL decrement counter each cycle; at counter 0 go to MEM_RESP; total latency mem_en-high-to-ready = WAIT_CYCLES+1 cycles.
REQ-020 In MEM_RESP, SHALL drive ready=1 for exactly one cycle with rdata valid, commit any write on that edge, return to MEM_IDLE.
REQ-021 A new access MAY start in the MEM_IDLE cycle immediately after MEM_RESP if mem_en is high.
REQ-022 mem_en falling in MEM_WAIT SHALL abort: return to MEM_IDLE, no ready pulse, no write, no side effects.
REQ-023 Addresses below 0xFE00 SHALL map to RAM index addr[ADDR_BITS-1:0] (higher bits ignored; aliasing by wrap-around).
REQ-024 0xFE00 KBSR: read {ready bit15, IE bit14, 14'b0}; write updates bit14 only.
REQ-025 0xFE02 KBDR: read {8'b0, latched char}; a read SHALL clear KBSR[15] at the MEM_RESP edge.
REQ-026 0xFE04 DSR: read {DSR[15], 15'b0}; writes ignored.
REQ-027 0xFE06 DDR: write with DSR[15]=1 latches wdata[7:0] into disp_char, clears DSR[15], sets disp_valid; write with DSR[15]=0 ignored; read returns {8'b0, disp_char}.
REQ-028 disp_ack while disp_valid=1 SHALL clear disp_valid and set DSR[15] next edge; disp_ack while disp_valid=0 ignored.
REQ-029 kb_strobe SHALL latch kb_char and set KBSR[15]; if KBSR[15] already 1, new character overwrites (overrun).
REQ-030 kb_strobe coinciding with a KBDR read commit: new character latched and KBSR[15] stays 1; the read returns the old character.
REQ-031 Other addresses 0xFE08-0xFFFF SHALL read 0x0000; writes ignored.

Reset
REQ-032 On rst=1 at a clock edge, SHALL set state MEM_IDLE, ready=0, rdata=0, disp_valid=0, disp_char=0, KBSR=0x0000, latched char=0, DSR[15]=1, kbd_int=0.
REQ-033 rst during MEM_WAIT or MEM_RESP SHALL abort the access with no write; RAM contents SHALL NOT be reset.
REQ-034 rst SHALL take priority over all simultaneous inputs.

Structure
REQ-035 MemStates enum (MEM_IDLE, MEM_WAIT, MEM_RESP) and address constants KBSR_ADDR=0xFE00, KBDR_ADDR=0xFE02, DSR_ADDR=0xFE04, DDR_ADDR=0xFE06 SHALL live in lc3Pkg.
REQ-036 RAM SHALL be one sub-module lc3_ram: single-port, synchronous write, combinational read, parameterised by ADDR_BITS.

Verification
REQ-037 Write 0x1234 to 0x3000, then read 0x3000, WAIT_CYCLES=2 -> ready pulse 3 cycles after each mem_en rise; read rdata=0x1234.
REQ-038 Write 0xBEEF to 0x3000 with ADDR_BITS=12, read 0x0000 -> rdata=0xBEEF (alias).
REQ-039 kb_strobe with kb_char=0x41, write KBSR 0x4000 -> kbd_int=1; read KBDR -> rdata=0x0041, then KBSR reads 0x4000, kbd_int=0.
REQ-040 Write DDR 0x0058 -> disp_valid=1, disp_char=0x58, DSR reads 0x0000; second DDR write 0x0059 ignored; disp_ack -> DSR reads 0x8000.
REQ-041 Write 0xAAAA to 0x3001, drop mem_en after 1 wait cycle -> no ready; subsequent read of 0x3001 returns prior value.
REQ-042 Assert rst mid-MEM_WAIT of a write -> no ready, no write, all outputs at REQ-032 values next cycle.

Source files
------------

// File: rtl/lc3_memory_responder_pkg.sv
// Shared types and memory-map constants for the LC-3 memory responder.
package lc3Pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_RESP
    } MemStates;

    // Memory-mapped device registers; everything below KBSR_ADDR is RAM.
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    // True when the word address falls in the RAM region of the map.
    function automatic logic is_ram_addr(input logic [15:0] a);
        return (a < KBSR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_memory_responder_ram.sv
// Single-port word RAM: synchronous write, combinational read.
// Contents are deliberately not reset so memory survives a CPU reset.
module lc3_ram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [15:0] mem [0:(2**ADDR_BITS)-1];

    // Commit a write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lc3_memory_responder.sv
// LC-3 memory responder: RAM plus keyboard and display device registers,
// answering CPU accesses after a fixed number of wait states.
module lc3_memory_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        r_w,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    input  logic        kb_strobe,
    input  logic [7:0]  kb_char,
    output logic        disp_valid,
    output logic [7:0]  disp_char,
    input  logic        disp_ack,
    output logic        kbd_int
);

    import lc3Pkg::*;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    MemStates    state;
    logic [3:0]  wait_cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        r_w_q;

    logic        kb_ready;
    logic        kb_ie;
    logic [7:0]  kb_data;
    logic        dsr_ready;

    logic [15:0] lookup_addr;
    logic [15:0] read_value;
    logic [15:0] ram_rdata;
    logic        ram_we;
    logic        commit;
    logic        commit_wr;
    logic        commit_rd;

    // In IDLE the live address is looked up so a zero-wait access can
    // answer immediately; otherwise the captured address is used.
    assign lookup_addr = (state == MEM_IDLE) ? addr : addr_q;

    // The RESP cycle is the only cycle in which an access has side effects.
    assign commit    = (state == MEM_RESP);
    assign commit_wr = commit &&  r_w_q;
    assign commit_rd = commit && !r_w_q;

    // Reset is folded in so a reset landing on the commit edge cannot write RAM.
    assign ram_we = commit_wr && is_ram_addr(addr_q) && !rst;

    assign kbd_int = kb_ready & kb_ie;

    lc3_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (lookup_addr[ADDR_BITS-1:0]),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // Address decode of the read value; unmapped device space reads as zero.
    always_comb begin
        read_value = 16'h0000;
        if (is_ram_addr(lookup_addr)) begin
            read_value = ram_rdata;
        end else begin
            case (lookup_addr)
                KBSR_ADDR: read_value = {kb_ready, kb_ie, 14'b0};
                KBDR_ADDR: read_value = {8'b0, kb_data};
                DSR_ADDR:  read_value = {dsr_ready, 15'b0};
                DDR_ADDR:  read_value = {8'b0, disp_char};
                default:   read_value = 16'h0000;
            endcase
        end
    end

    // Access sequencer: capture, count wait states, pulse ready for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MEM_IDLE;
            ready    <= 1'b0;
            rdata    <= 16'h0000;
            wait_cnt <= 4'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            r_w_q    <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    ready <= 1'b0;
                    rdata <= 16'h0000;
                    if (mem_en) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        r_w_q   <= r_w;
                        if (WAIT_CYCLES == 0) begin
                            state <= MEM_RESP;
                            ready <= 1'b1;
                            rdata <= r_w ? 16'h0000 : read_value;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!mem_en) begin
                        state    <= MEM_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt <= 4'd1) begin
                        state    <= MEM_RESP;
                        ready    <= 1'b1;
                        rdata    <= r_w_q ? 16'h0000 : read_value;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                MEM_RESP: begin
                    ready <= 1'b0;
                    rdata <= 16'h0000;
                    state <= MEM_IDLE;
                end
                default: begin
                    ready <= 1'b0;
                    rdata <= 16'h0000;
                    state <= MEM_IDLE;
                end
            endcase
        end
    end

    // Keyboard and display device registers, updated by commits and I/O events.
    always_ff @(posedge clk) begin
        if (rst) begin
            kb_ready   <= 1'b0;
            kb_ie      <= 1'b0;
            kb_data    <= 8'h00;
            dsr_ready  <= 1'b1;
            disp_valid <= 1'b0;
            disp_char  <= 8'h00;
        end else begin
            if (commit_wr && addr_q == KBSR_ADDR) begin
                kb_ie <= wdata_q[14];
            end
            if (commit_rd && addr_q == KBDR_ADDR) begin
                kb_ready <= 1'b0;
            end
            if (kb_strobe) begin
                kb_data  <= kb_char;
                kb_ready <= 1'b1;
            end
            if (commit_wr && addr_q == DDR_ADDR && dsr_ready) begin
                disp_char  <= wdata_q[7:0];
                dsr_ready  <= 1'b0;
                disp_valid <= 1'b1;
            end else if (disp_ack && disp_valid) begin
                disp_valid <= 1'b0;
                dsr_ready  <= 1'b1;
            end
        end
    end

endmodule
